// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared FSM encoding and defaults for the instruction fetch path
//
// Purpose: state encoding of the IR fetch FSM, default bus width and memory
// timeout, and a helper that sizes the timeout counter.
// Ports: none (package).
package cpu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_e;

  // clog2 collapses to 0 for TIMEOUT=1; keep at least one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/ir_timeout_cnt.sv
// rtl/ir_timeout_cnt.sv - saturating wait counter that flags a memory timeout
//
// Purpose: counts cycles spent waiting on a busy memory; saturates at
// TIMEOUT-1 and reports expiry there.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset, clears the count
//   clr_i      clear count to 0 (has priority over en_i)
//   en_i       advance count by one
//   expired_o  count has reached TIMEOUT-1
module ir_timeout_cnt
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      // Hold at LAST so the count never wraps.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ir_fetch.sv
// rtl/ir_fetch.sv - instruction register with memory fetch FSM and timeout
//
// Purpose: holds the current instruction. Loads it either directly from Bus
// (ldIR) or by a memory fetch (Fetch) that waits out MemBusy, giving up with a
// sticky Fault after TIMEOUT busy wait cycles.
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset
//   Bus      shared datapath bus
//   Fetch    request a memory fetch into IR (wins over ldIR)
//   ldIR     load IR directly from Bus
//   MemBusy  memory not ready
//   MemRd    memory read strobe (REQ and WAIT)
//   Data     held instruction
//   Opcode   Data[31:26]
//   Done     one-cycle pulse after IR updates from a fetch
//   Fault    sticky memory timeout flag
//   Busy     FSM not idle
module ir_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Bus,
  input  logic              Fetch,
  input  logic              ldIR,
  input  logic              MemBusy,
  output logic              MemRd,
  output logic [DATA_W-1:0] Data,
  output logic [5:0]        Opcode,
  output logic              Done,
  output logic              Fault,
  output logic              Busy
);

  fetch_state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic done_q, done_d;
  logic fault_q, fault_d;
  logic cnt_clr, cnt_en, cnt_expired;

  ir_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Fetch) begin
          state_d = ST_REQ;
        end else if (ldIR) begin
          data_d = Bus;
        end
      end
      ST_REQ: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!MemBusy) begin
          data_d  = Bus;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_expired) begin
          // Give up: Data keeps its old value and no Done is raised.
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign MemRd  = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign Busy   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign Data   = data_q;
  assign Opcode = data_q[31:26];
  assign Done   = done_q;
  assign Fault  = fault_q;

endmodule

// File: doc/ir_fetch.md
IR_FETCH -- requirements
Module: ir_fetch

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, bus and instruction width; TIMEOUT, default 16, maximum wait cycles for MemBusy.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- Bus  in  DATA_W  shared datapath bus
- Fetch  in  1  microcode request to fetch a word from memory into IR
- ldIR  in  1  microcode direct load of IR from Bus
- MemBusy  in  1  memory not ready
- MemRd  out  1  memory read strobe
- Data  out  DATA_W  held instruction, drives ImmGen Data input
- Opcode  out  6  Data[31:26]
- Done  out  1  one-cycle pulse when IR updates from a fetch
- Fault  out  1  sticky memory timeout flag
- Busy  out  1  high whenever the FSM is not IDLE
REQ-003 The clock SHALL be the only clock, and the reset SHALL be synchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-005 In IDLE, Fetch=1 SHALL move the FSM to REQ. In IDLE with Fetch=0, ldIR=1 SHALL load Bus into Data at the next edge, with no Done pulse.
REQ-006 If Fetch and ldIR are both 1 in IDLE, Fetch SHALL win and ldIR SHALL be ignored.
REQ-007 In REQ, MemRd SHALL be 1 and the FSM SHALL move to WAIT. The timeout counter SHALL clear to 0.
REQ-008 In WAIT, MemRd SHALL stay 1 while MemBusy=1, and the counter SHALL increment by 1 per cycle.
REQ-009 In WAIT with MemBusy=0, the block SHALL capture Bus into Data at that edge, pulse Done=1 for the following cycle, and return to IDLE.
REQ-010 Minimum fetch latency SHALL be 2 cycles: Fetch sampled at edge N, Data valid and Done=1 after edge N+2.
REQ-011 If the counter reaches TIMEOUT-1 while MemBusy=1, the block SHALL set Fault=1, return to IDLE, leave Data unchanged, and not pulse Done.
REQ-012 Fault SHALL clear only on reset.
REQ-013 Fetch and ldIR SHALL be ignored outside IDLE.
REQ-014 Opcode SHALL always equal Data[31:26] (combinational).
REQ-015 Busy SHALL be 1 exactly in REQ and WAIT.
REQ-016 The counter width SHALL be clog2(TIMEOUT) and SHALL never wrap past TIMEOUT-1.

Reset
REQ-017 With rst_n=0 at an edge, the block SHALL go to: state IDLE, Data=0, counter=0, MemRd=0, Done=0, Fault=0, Busy=0.
REQ-018 Reset SHALL take priority over all inputs.
REQ-019 Reset asserted mid-fetch SHALL abandon the fetch: no Done pulse and no Data capture.

Structure
REQ-020 The state encoding (IDLE=2'b00, REQ=2'b01, WAIT=2'b10) and default DATA_W and TIMEOUT SHALL live in a shared package, cpu_pkg.
REQ-021 The timeout counter SHALL be a separate sub-module, ir_timeout_cnt, with clear, enable and expiry ports. All other logic SHALL be flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then idle cycles -> Data=0, MemRd=0, Done=0, Fault=0.
- Fetch pulse, MemBusy=0, Bus=32'h0000ffff -> MemRd high for 2 cycles, Data=32'h0000ffff, single Done pulse at cycle 2, Opcode=6'h00.
- Fetch, MemBusy=1 for 5 cycles, then 0 with Bus=32'hffffffff -> Data=32'hffffffff 7 cycles after Fetch, Opcode=6'h3f.
- Fetch with MemBusy held 1 -> Fault=1 after TIMEOUT wait cycles, Data unchanged, no Done, FSM back in IDLE.
- ldIR with Bus=32'h03ffffff in IDLE -> Data=32'h03ffffff next cycle, Done=0; Fetch and ldIR asserted together -> fetch path taken.
- rst_n=0 during WAIT -> IDLE, Data=0, no Done pulse, Fault cleared.
